// File: rtl/uart_tx_fifo_if.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_if
// Producer-side bundle for the uart_tx_fifo transmitter.
//   tx_data  : byte to enqueue (producer -> transmitter)
//   tx_write : enqueue strobe  (producer -> transmitter)
//   full     : FIFO full, a write now is refused
//   idle     : FIFO empty and serializer idle, line quiescent high
//   overflow : one-cycle pulse when a write hits a full FIFO
//   tx       : registered serial line, idles high
// master = producer side, slave = the transmitter.
// ----------------------------------------------------------------------------
interface uart_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_write;
    logic       full;
    logic       idle;
    logic       overflow;
    logic       tx;

    modport master (output tx_data, tx_write, input full, idle, overflow, tx);
    modport slave  (input tx_data, tx_write, output full, idle, overflow, tx);
endinterface

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// 8N1 UART transmitter fed by a small write-side FIFO, so a producer can
// push bursts of bytes without tracking per-byte busy timing.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (aborts any frame, drops the queue)
//   bus  : uart_tx_fifo_if.slave -- tx_data/tx_write in; full/idle/overflow/tx out
// Parameters: CLK_FREQ, BAUDRATE (bit period = CLK_FREQ/BAUDRATE cycles),
//             FIFO_DEPTH (power of two, >= 2).
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 12_000_000,
    parameter int BAUDRATE   = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fifo_if.slave  bus
);
    localparam int DIVIDER = CLK_FREQ / BAUDRATE;
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = $clog2(FIFO_DEPTH + 1);
    localparam int BW      = $clog2(DIVIDER);

    localparam logic [BW-1:0] BAUD_LAST = BW'(DIVIDER - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    if (DIVIDER < 2) begin : g_bad_divider
        $error("uart_tx_fifo: CLK_FREQ/BAUDRATE must be >= 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, have_data, wr_en, pop;

    // serializer
    state_t        state, state_n;
    logic [BW-1:0] baud_cnt, baud_cnt_n;
    logic [7:0]    shift, shift_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic          tx_q, tx_n;
    logic          ovf_q;
    logic          baud_end;

    // Space is judged on the registered count only: a pop on this edge does
    // not make room for a write on the same edge.
    assign full      = (count == DEPTH_C);
    assign have_data = (count != '0);
    assign wr_en     = bus.tx_write && !full;
    assign baud_end  = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_end ? '0 : baud_cnt + 1'b1;
        shift_n    = shift;
        bit_idx_n  = bit_idx;
        tx_n       = tx_q;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                tx_n       = 1'b1;
                baud_cnt_n = '0;
                if (have_data) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_end) begin
                    tx_n      = shift[0];
                    bit_idx_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_idx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        // next bit is shift[1] before the shift lands
                        shift_n   = shift >> 1;
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = shift[1];
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    // chain straight into the next start bit: no idle gap
                    if (have_data) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            shift    <= '0;
            bit_idx  <= '0;
            tx_q     <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            shift    <= shift_n;
            bit_idx  <= bit_idx_n;
            tx_q     <= tx_n;
            ovf_q    <= bus.tx_write && full;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // storage needs no reset: the cleared count masks stale entries
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[wr_ptr] <= bus.tx_data;
    end

    assign bus.tx       = tx_q;
    assign bus.full     = full;
    assign bus.idle     = !have_data && (state == IDLE);
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
    localparam int CLK_FREQ = 12_000_000;
    localparam int BAUDRATE = 921_600;
    localparam int DEPTH    = 4;
    localparam int D        = CLK_FREQ / BAUDRATE;   // 13
    localparam int FRAME    = 10 * D;                // 130

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_fifo_if bus();

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUDRATE), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: byte queue + frame position -------
    logic [7:0] mq[$];
    logic [7:0] popped_q[$];
    logic       m_act = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_ovf = 1'b0;
    bit         fullp;
    bit         model_ok = 1'b0;
    int         cyc = 0;

    // receiver-side decoder state (also cleared by reset in the model block)
    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_q[$];
    int         falls[$];

    always @(posedge clk) begin
        cyc++;
        model_ok = 1'b1;
        if (rst) begin
            mq.delete();
            m_act   = 1'b0;
            m_pos   = 0;
            m_ovf   = 1'b0;
            rx_busy = 1'b0;
        end else begin
            fullp = (mq.size() == DEPTH);
            if (m_act && m_pos == FRAME - 1) m_act = 1'b0;
            else if (m_act)                  m_pos++;
            if (!m_act && mq.size() > 0) begin
                m_byte = mq.pop_front();
                popped_q.push_back(m_byte);
                m_act = 1'b1;
                m_pos = 0;
            end
            if (bus.tx_write && !fullp) mq.push_back(bus.tx_data);
            m_ovf = bus.tx_write && fullp;
        end
    end

    function automatic logic exp_tx();
        int k;
        if (!m_act) return 1'b1;
        k = m_pos / D;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    // ---------------- per-cycle compare ------------------------------------
    int ov_cnt = 0;
    bit full_seen = 1'b0;
    always @(negedge clk) begin
        if (model_ok) begin
            chk("tx",       bus.tx,       exp_tx());
            chk("full",     bus.full,     mq.size() == DEPTH);
            chk("idle",     bus.idle,     mq.size() == 0 && !m_act);
            chk("overflow", bus.overflow, m_ovf);
            if (bus.full === 1'b1)     full_seen = 1'b1;
            if (bus.overflow === 1'b1) ov_cnt++;
        end
    end

    // ---------------- line decoder (mid-bit sampling) ----------------------
    always @(negedge clk) begin
        if (model_ok) begin
            if (!rx_busy) begin
                if (bus.tx === 1'b0) begin
                    rx_busy = 1'b1;
                    rx_cnt  = 0;
                    falls.push_back(cyc);
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % D == D / 2) begin
                    if (rx_cnt / D >= 1 && rx_cnt / D <= 8) rx_sh[rx_cnt/D-1] = bus.tx;
                    else if (rx_cnt / D == 9) begin
                        chk("stop_bit", bus.tx, 1'b1);
                        rx_q.push_back(rx_sh);
                        rx_busy = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ---------------
    task automatic put(input logic [7:0] b);
        bus.tx_write = 1'b1;
        bus.tx_data  = b;
        @(negedge clk);
    endtask

    task automatic clear_logs();
        rx_q.delete();
        falls.delete();
        popped_q.delete();
        ov_cnt    = 0;
        full_seen = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (bus.idle !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", bus.idle, 1'b1);
    endtask

    task automatic wait_fall(input int need, input int maxc);
        int n = 0;
        while (falls.size() < need && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("fall_timeout", falls.size() >= need, 1'b1);
    endtask

    task automatic wait_pos(input int idx, input int pos);
        int f;
        f = (falls.size() > idx) ? falls[idx] : cyc;
        while (cyc < f + pos) @(negedge clk);
    endtask

    logic       exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] burst    [4]  = '{8'h00, 8'h55, 8'hFF, 8'h81};

    initial begin
        int lows;
        int n;
        bus.tx_write = 1'b0;
        bus.tx_data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", bus.tx, 1'b1);
        chk("rst_full", bus.full, 1'b0);
        chk("rst_idle", bus.idle, 1'b1);
        chk("rst_overflow", bus.overflow, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // basic frame 0xA5
        clear_logs();
        put(8'hA5);
        bus.tx_write = 1'b0;
        chk("basic_tx_before_fall", bus.tx, 1'b1);
        chk("basic_idle_drop", bus.idle, 1'b0);
        @(negedge clk);
        chk("basic_fall_latency", bus.tx, 1'b0);
        repeat (6) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) repeat (D) @(negedge clk);
            chk($sformatf("basic_bit%0d", k), bus.tx, exp_bits[k]);
        end
        repeat (6) @(negedge clk);
        chk("basic_idle_at_129", bus.idle, 1'b0);
        @(negedge clk);
        chk("basic_idle_at_130", bus.idle, 1'b1);
        chk("basic_rx_count", rx_q.size(), 1);
        chk("basic_rx_byte", (rx_q.size() > 0) ? rx_q[0] : 8'h00, 8'hA5);

        // burst of four
        clear_logs();
        for (int i = 0; i < 4; i++) put(burst[i]);
        bus.tx_write = 1'b0;
        wait_idle(4 * FRAME + 20);
        chk("burst_full_never", full_seen, 1'b0);
        chk("burst_rx_count", rx_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("burst_rx%0d", i), (rx_q.size() > i) ? rx_q[i] : 8'hxx, burst[i]);
        for (int i = 1; i < 4; i++)
            chk($sformatf("burst_gap%0d", i), (falls.size() > i) ? falls[i] - falls[i-1] : -1, FRAME);

        // overflow: six writes
        clear_logs();
        for (int i = 0; i < 6; i++) put(8'(i * 17 + 3));
        bus.tx_write = 1'b0;
        wait_idle(6 * FRAME + 20);
        chk("ovf_pulses", ov_cnt, 1);
        chk("ovf_full_seen", full_seen, 1'b1);
        chk("ovf_frames", rx_q.size(), 5);

        // reset during data bit 3 of 0x0F with two bytes queued
        clear_logs();
        put(8'h0F); put(8'h11); put(8'h22);
        bus.tx_write = 1'b0;
        wait_fall(1, 10);
        wait_pos(0, 4 * D + 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_tx", bus.tx, 1'b1);
        chk("midrst_full", bus.full, 1'b0);
        chk("midrst_idle", bus.idle, 1'b1);
        clear_logs();
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) lows++;
        end
        chk("midrst_line_high", lows, 0);
        chk("midrst_no_frames", falls.size(), 0);

        // write during the stop bit of the last queued byte
        clear_logs();
        put(8'h3C);
        bus.tx_write = 1'b0;
        wait_fall(1, 10);
        wait_pos(0, 9 * D + 4);
        put(8'hC3);
        bus.tx_write = 1'b0;
        wait_fall(2, 2 * D);
        wait_idle(2 * FRAME);
        chk("stopwr_gap", (falls.size() > 1) ? falls[1] - falls[0] : -1, FRAME);
        chk("stopwr_rx1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'hC3);

        // write on the pop edge while full is refused
        clear_logs();
        for (int i = 0; i < 5; i++) put(8'(8'hB0 + i));
        bus.tx_write = 1'b0;
        wait_fall(1, 10);
        wait_pos(0, FRAME - 1);
        put(8'hEE);
        bus.tx_write = 1'b0;
        chk("popfull_overflow", bus.overflow, 1'b1);
        chk("popfull_full_after", bus.full, 1'b0);
        wait_idle(5 * FRAME);
        chk("popfull_frames", rx_q.size(), 5);
        chk("popfull_pulses", ov_cnt, 1);

        // random traffic, end-to-end byte order against the model
        clear_logs();
        repeat (2500) begin
            bus.tx_write = ($urandom_range(0, 99) < 3);
            bus.tx_data  = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        bus.tx_write = 1'b0;
        wait_idle(6 * FRAME + 20);
        chk("rand_count", rx_q.size(), popped_q.size());
        n = (rx_q.size() < popped_q.size()) ? rx_q.size() : popped_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("rand_byte%0d", i), rx_q[i], popped_q[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end
endmodule
